// File: rtl/light_phase_monitor.sv
// Passive checker for the intersection lamp outputs: decodes phases,
// measures their lengths and latches the first sequencing/timing fault.
module light_phase_monitor #(
    parameter int unsigned CLK_FREQ          = 50_000_000,
    parameter int unsigned YELLOW_DELAY_TIME = 40,
    parameter int unsigned TOL               = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NS_RED,
    input  logic        NS_YELLOW,
    input  logic        NS_GREEN,
    input  logic        EW_RED,
    input  logic        EW_YELLOW,
    input  logic        EW_GREEN,
    input  logic [31:0] NS_GREEN_DELAY,
    input  logic [31:0] EW_GREEN_DELAY,
    input  logic        clear_fault,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        phase_done,
    output logic [31:0] phase_len,
    output logic [15:0] cycle_count,
    output logic        fault,
    output logic [2:0]  fault_code
);

    localparam logic [31:0] T_YELLOW =
        32'(64'(YELLOW_DELAY_TIME) * 64'(CLK_FREQ) / 64'd1000);

    localparam logic [1:0] PH_NSG = 2'd0;
    localparam logic [1:0] PH_NSY = 2'd1;
    localparam logic [1:0] PH_EWG = 2'd2;
    localparam logic [1:0] PH_EWY = 2'd3;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_ILL   = 3'd1;
    localparam logic [2:0] F_SEQ   = 3'd2;
    localparam logic [2:0] F_TO    = 3'd3;
    localparam logic [2:0] F_SHORT = 3'd4;

    // Pattern bit order: {NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G}
    function automatic logic [2:0] decode(input logic [5:0] p);
        logic [2:0] r;
        r = 3'b000;
        case (p)
            6'b001_100: r = {1'b1, PH_NSG};
            6'b010_100: r = {1'b1, PH_NSY};
            6'b100_001: r = {1'b1, PH_EWG};
            6'b100_010: r = {1'b1, PH_EWY};
            default:    r = 3'b000;
        endcase
        return r;
    endfunction

    logic [5:0]  lamps;
    logic [5:0]  samp_q;
    logic [5:0]  cur_q;
    logic [31:0] run_q;
    logic        sync_q;
    logic        chk_q;
    logic        to_done_q;

    logic        s_legal, c_legal;
    logic [1:0]  s_ph, c_ph, succ_ph;
    logic        changed, ph_end;
    logic [31:0] run_inc, exp_len;
    logic [32:0] lo_len;
    logic [33:0] to_lim;
    logic        ev_ill, ev_seq, ev_to, ev_short, wrap;
    logic [2:0]  ev_code;

    assign lamps = {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN};

    always_comb begin
        {s_legal, s_ph} = decode(samp_q);
        {c_legal, c_ph} = decode(cur_q);
        succ_ph = c_ph + 2'd1;
        changed = samp_q != cur_q;
        ph_end  = changed && s_legal && c_legal;
        run_inc = (&run_q) ? run_q : run_q + 32'd1;
        exp_len = T_YELLOW;
        if (c_ph == PH_NSG) exp_len = NS_GREEN_DELAY;
        if (c_ph == PH_EWG) exp_len = EW_GREEN_DELAY;
        // 33/34-bit bounds so huge delays never wrap
        lo_len = ({1'b0, exp_len} > 33'(TOL)) ?
                 {1'b0, exp_len} - 33'(TOL) : 33'd0;
        to_lim = {2'b00, exp_len} + 34'(TOL) + 34'd1;
        ev_ill   = changed && !s_legal;
        ev_seq   = ph_end && sync_q && (s_ph != succ_ph);
        ev_to    = !changed && chk_q && c_legal && !to_done_q &&
                   ({2'b00, run_inc} == to_lim);
        ev_short = ph_end && chk_q && ({1'b0, run_q} < lo_len);
        wrap     = ph_end && sync_q && c_ph == PH_EWY && s_ph == PH_NSG;
        ev_code  = F_NONE;
        if (ev_short) ev_code = F_SHORT;
        if (ev_to)    ev_code = F_TO;
        if (ev_seq)   ev_code = F_SEQ;
        if (ev_ill)   ev_code = F_ILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q      <= '0;
            cur_q       <= '0;
            run_q       <= '0;
            sync_q      <= 1'b0;
            chk_q       <= 1'b0;
            to_done_q   <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
            phase_done  <= 1'b0;
            phase_len   <= '0;
            cycle_count <= '0;
            fault       <= 1'b0;
            fault_code  <= '0;
        end else begin
            samp_q      <= lamps;
            phase_valid <= s_legal;
            phase_done  <= ph_end;
            if (s_legal) phase <= s_ph;
            if (ph_end) phase_len <= run_q;
            if (changed) begin
                cur_q     <= samp_q;
                run_q     <= 32'd1;
                to_done_q <= 1'b0;
                chk_q     <= ph_end && sync_q;
            end else begin
                run_q <= run_inc;
                if (ev_to) to_done_q <= 1'b1;
            end
            if (!s_legal) sync_q <= 1'b0;
            else if (changed) sync_q <= 1'b1;
            if (wrap) cycle_count <= cycle_count + 16'd1;
            // A fresh event outranks a simultaneous clear
            if (ev_code != F_NONE && (!fault || clear_fault)) begin
                fault      <= 1'b1;
                fault_code <= ev_code;
            end else if (clear_fault) begin
                fault      <= 1'b0;
                fault_code <= F_NONE;
            end
        end
    end

endmodule

// File: tb/tb_light_phase_monitor.sv
// Directed bench for light_phase_monitor: nominal table plus
// hand sequences for illegal, sequence, timeout, short and reset cases.
module tb_light_phase_monitor;

    localparam logic [5:0] P_NSG = 6'b001_100;
    localparam logic [5:0] P_NSY = 6'b010_100;
    localparam logic [5:0] P_EWG = 6'b100_001;
    localparam logic [5:0] P_EWY = 6'b100_010;
    localparam logic [5:0] P_BAD = 6'b001_001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  lamps;
    logic        ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
    logic [31:0] ns_dly, ew_dly;
    logic        clear_fault;
    logic [1:0]  phase;
    logic        phase_valid, phase_done, fault;
    logic [31:0] phase_len;
    logic [15:0] cycle_count;
    logic [2:0]  fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps;

    always #5 clk = ~clk;

    light_phase_monitor #(
        .CLK_FREQ(1000),
        .YELLOW_DELAY_TIME(4),
        .TOL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .NS_RED(ns_r),
        .NS_YELLOW(ns_y),
        .NS_GREEN(ns_g),
        .EW_RED(ew_r),
        .EW_YELLOW(ew_y),
        .EW_GREEN(ew_g),
        .NS_GREEN_DELAY(ns_dly),
        .EW_GREEN_DELAY(ew_dly),
        .clear_fault(clear_fault),
        .phase(phase),
        .phase_valid(phase_valid),
        .phase_done(phase_done),
        .phase_len(phase_len),
        .cycle_count(cycle_count),
        .fault(fault),
        .fault_code(fault_code)
    );

    typedef struct {
        logic [5:0]  pat;
        int          n;
        logic        done;
        logic [1:0]  ph;
        logic [31:0] len;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_fault(input string nm, input logic f,
                             input logic [2:0] c);
        chk({nm, "_fault"}, 32'(fault), 32'(f));
        chk({nm, "_code"}, 32'(fault_code), 32'(c));
    endtask

    initial begin
        tv[0] = '{P_NSG, 12, 1'b0, 2'd0, 32'd0,  16'd0};
        tv[1] = '{P_NSY, 5,  1'b1, 2'd1, 32'd12, 16'd0};
        tv[2] = '{P_EWG, 11, 1'b1, 2'd2, 32'd5,  16'd0};
        tv[3] = '{P_EWY, 5,  1'b1, 2'd3, 32'd11, 16'd0};
        tv[4] = '{P_NSG, 10, 1'b1, 2'd0, 32'd5,  16'd1};
        tv[5] = '{P_NSY, 4,  1'b1, 2'd1, 32'd10, 16'd1};
        tv[6] = '{P_EWG, 10, 1'b1, 2'd2, 32'd4,  16'd1};
        tv[7] = '{P_EWY, 4,  1'b1, 2'd3, 32'd10, 16'd1};
        tv[8] = '{P_NSG, 11, 1'b1, 2'd0, 32'd4,  16'd2};

        rst = 1'b0;
        lamps = 6'd0;
        ns_dly = 32'd10;
        ew_dly = 32'd10;
        clear_fault = 1'b0;
        tick(2);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_valid", 32'(phase_valid), 32'd0);
        chk("rst_len", phase_len, 32'd0);
        chk("rst_cnt", 32'(cycle_count), 32'd0);
        chk_fault("rst", 1'b0, 3'd0);
        rst = 1'b1;
        tick(1);

        // nominal sequence
        for (int v = 0; v < 9; v++) begin
            lamps = tv[v].pat;
            for (int c = 0; c < tv[v].n; c++) begin
                tick(1);
                if (c == 1) begin
                    chk($sformatf("v%0d_done", v), 32'(phase_done),
                        32'(tv[v].done));
                    chk($sformatf("v%0d_phase", v), 32'(phase),
                        32'(tv[v].ph));
                    chk($sformatf("v%0d_len", v), phase_len, tv[v].len);
                    chk($sformatf("v%0d_cnt", v), 32'(cycle_count),
                        32'(tv[v].cnt));
                    chk($sformatf("v%0d_valid", v), 32'(phase_valid), 32'd1);
                    chk($sformatf("v%0d_fault", v), 32'(fault), 32'd0);
                end
                if (c == 2)
                    chk($sformatf("v%0d_pulse", v), 32'(phase_done), 32'd0);
            end
        end

        // illegal pattern for one cycle, then out-of-order resync
        lamps = P_BAD;
        tick(1);
        lamps = P_EWG;
        tick(1);
        chk_fault("ill", 1'b1, 3'd1);
        chk("ill_valid", 32'(phase_valid), 32'd0);
        chk("ill_phase", 32'(phase), 32'd0);
        chk("ill_done", 32'(phase_done), 32'd0);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk_fault("ill_clr", 1'b0, 3'd0);
        tick(1);
        chk("resync_phase", 32'(phase), 32'd2);
        chk("resync_valid", 32'(phase_valid), 32'd1);
        chk("resync_fault", 32'(fault), 32'd0);
        tick(2);
        lamps = P_EWY;
        tick(4);
        lamps = P_NSG;
        tick(10);

        // NSG jumps straight to EWG
        lamps = P_EWG;
        tick(2);
        chk_fault("seq", 1'b1, 3'd2);
        chk("seq_len", phase_len, 32'd10);
        chk("seq_done", 32'(phase_done), 32'd1);
        chk("seq_cnt", 32'(cycle_count), 32'd3);

        // NSG held past E+TOL
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk_fault("clr2", 1'b0, 3'd0);
        tick(7);
        lamps = P_EWY;
        tick(4);
        lamps = P_NSG;
        tick(12);
        chk("to_early", 32'(fault), 32'd0);
        chk("to_cnt", 32'(cycle_count), 32'd4);
        tick(1);
        chk_fault("to", 1'b1, 3'd3);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk_fault("to_clr", 1'b0, 3'd0);
        tick(10);
        chk_fault("to_once", 1'b0, 3'd0);

        // short yellow
        lamps = P_NSY;
        tick(2);
        lamps = P_EWG;
        tick(2);
        chk_fault("short", 1'b1, 3'd4);
        chk("short_len", phase_len, 32'd2);
        chk("short_phase", 32'(phase), 32'd2);

        // clear collides with a new SEQ event
        lamps = P_NSY;
        tick(1);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk_fault("clrseq", 1'b1, 3'd2);
        chk("clrseq_len", phase_len, 32'd2);
        chk("clrseq_phase", 32'(phase), 32'd1);

        // asynchronous reset mid-EWG
        lamps = P_EWG;
        tick(4);
        chk("pre_rst_phase", 32'(phase), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_valid", 32'(phase_valid), 32'd0);
        chk("arst_done", 32'(phase_done), 32'd0);
        chk("arst_len", phase_len, 32'd0);
        chk("arst_cnt", 32'(cycle_count), 32'd0);
        chk_fault("arst", 1'b0, 3'd0);
        tick(1);
        rst = 1'b1;
        tick(3);
        chk("post_phase", 32'(phase), 32'd2);
        chk("post_valid", 32'(phase_valid), 32'd1);
        lamps = P_EWY;
        tick(2);
        chk("post_ewy", 32'(phase), 32'd3);
        chk("post_done", 32'(phase_done), 32'd1);
        chk_fault("post_first", 1'b0, 3'd0);
        tick(2);
        lamps = P_NSG;
        tick(2);
        chk_fault("post_wrap", 1'b0, 3'd0);
        chk("post_cnt", 32'(cycle_count), 32'd1);
        chk("post_len", phase_len, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
